// File: rtl/mc_ctrl_seq_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, functs,
// ALU control codes (also used by the ALU), state enum and mux select values.
package mc_ctrl_seq_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_B_BUS  = 2'b00;
    localparam logic [1:0] ALU_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_B_IMM  = 2'b10;
    localparam logic [1:0] ALU_B_BR   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_R   = 4'd7,
        S_WB_I   = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP = 4'd12
`endif
    } state_t;

endpackage

// File: rtl/mc_ctrl_seq_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
// mem_read/mem_write stay asserted until the cycle mem_ready=1; that cycle completes the access.
interface mc_ctrl_seq_if #(
    parameter int ALU_CTRL_W = 4
);
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero;
    logic                  mem_ready;
    logic                  pc_write;
    logic [1:0]            pc_src;
    logic                  ir_write;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic                  ext_op;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [3:0]            state_o;
    logic                  illegal;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               ext_op, alu_ctrl, state_o, illegal
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               ext_op, alu_ctrl, state_o, illegal
    );
endinterface

// File: rtl/mc_alu_dec.sv
// Combinational opcode/funct -> ALU control decoder with a legality flag.
module mc_alu_dec
    import mc_ctrl_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       legal
);
    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_SLL:  alu_ctrl = ALU_SLL;
                    FN_SRL:  alu_ctrl = ALU_SRL;
                    default: legal    = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI, OP_J: alu_ctrl = ALU_ADD;
            OP_ORI:                      alu_ctrl = ALU_OR;
            OP_BEQ, OP_BNE:              alu_ctrl = ALU_SUB;
            default:                     legal    = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_seq.sv
// Multi-cycle MIPS control sequencer: one state register drives every datapath
// enable/select. Define ILLEGAL_TRAP_EN to trap illegal instructions instead of NOPing them.
module mc_ctrl_seq
    import mc_ctrl_seq_pkg::*;
#(
    parameter int RESET_HOLD = 2,
    parameter int ALU_CTRL_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    mc_ctrl_seq_if.master bus
);
    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);
`ifdef ILLEGAL_TRAP_EN
    localparam state_t ILL_NEXT = S_TRAP;
`else
    localparam state_t ILL_NEXT = S_FETCH;
`endif

    state_t     state, next;
    logic [3:0] hold_cnt;
    logic [3:0] dec_alu;
    logic       dec_legal;

    logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_code;

    mc_alu_dec u_alu_dec (
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            hold_cnt <= 4'd0;
        end else begin
            state    <= next;
            hold_cnt <= (state == S_IDLE) ? hold_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        next       = state;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALU_B_BUS;
        ext_op     = 1'b0;
        alu_code   = ALU_AND;
        case (state)
            S_IDLE: if (hold_cnt == HOLD_LAST) next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALU_B_FOUR;
                alu_code  = ALU_ADD;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    next     = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = ALU_B_BR;
                alu_code  = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:                        next = S_EXEC_R;
                    OP_LW, OP_SW, OP_ADDI, OP_ORI:   next = S_EXEC_I;
                    OP_BEQ, OP_BNE:                  next = S_BRANCH;
                    OP_J:                            next = S_JUMP;
                    default:                         next = ILL_NEXT;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_BUS;
                alu_code  = dec_alu;
                next      = dec_legal ? S_WB_R : ILL_NEXT;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_IMM;
                ext_op    = (bus.opcode != OP_ORI);
                alu_code  = dec_alu;
                case (bus.opcode)
                    OP_LW:   next = S_MEM_RD;
                    OP_SW:   next = S_MEM_WR;
                    default: next = S_WB_I;
                endcase
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (bus.mem_ready) next = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (bus.mem_ready) next = S_FETCH;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                next      = S_FETCH;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                next      = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next       = S_FETCH;
            end
            S_BRANCH: begin
                // BNE shares the SUB compare and only inverts the qualifier
                alu_src_a = 1'b1;
                alu_src_b = ALU_B_BUS;
                alu_code  = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
                next      = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
                next     = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: next = S_TRAP;
`endif
            default: next = S_IDLE;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 trap_q <= 1'b0;
        else if (next == S_TRAP)  trap_q <= 1'b1;
    end
    assign bus.illegal = trap_q | (state == S_TRAP);
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.ir_write   = ir_write;
    assign bus.i_or_d     = i_or_d;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_dst    = reg_dst;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.ext_op     = ext_op;
    assign bus.alu_ctrl   = ALU_CTRL_W'(alu_code);
    assign bus.state_o    = state;
endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Directed bench for mc_ctrl_seq: steps through each instruction class and
// compares the full control vector against hand-computed values every cycle.
module tb_mc_ctrl_seq;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mc_ctrl_seq_if #(.ALU_CTRL_W(4)) bus ();

    mc_ctrl_seq #(.RESET_HOLD(2), .ALU_CTRL_W(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [22:0] obs;
    assign obs = {bus.pc_write, bus.pc_src, bus.ir_write, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.alu_ctrl,
                  bus.state_o, bus.illegal};

    function automatic logic [22:0] pk(
        input logic pw, input logic [1:0] ps, input logic irw, input logic iod,
        input logic mr, input logic mw, input logic mtr, input logic rd,
        input logic rw, input logic asa, input logic [1:0] asb, input logic ext,
        input logic [3:0] alu, input logic [3:0] st, input logic ill);
        return {pw, ps, irw, iod, mr, mw, mtr, rd, rw, asa, asb, ext, alu, st, ill};
    endfunction

    //                              pw ps    irw iod mr mw mtr rd rw asa asb   ext alu      st     ill
    localparam logic [22:0] V_IDLE    = pk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'd0,  0);
    localparam logic [22:0] V_FETCH   = pk(1, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd1, 0, 4'b0010, 4'd1,  0);
    localparam logic [22:0] V_FWAIT   = pk(0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 0, 4'b0010, 4'd1,  0);
    localparam logic [22:0] V_DECODE  = pk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0, 4'b0010, 4'd2,  0);
    localparam logic [22:0] V_EXR_ADD = pk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 4'b0010, 4'd3,  0);
    localparam logic [22:0] V_EXI_ORI = pk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 4'b0001, 4'd4,  0);
    localparam logic [22:0] V_EXI_ADD = pk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 1, 4'b0010, 4'd4,  0);
    localparam logic [22:0] V_MEM_RD  = pk(0, 2'd0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'd5,  0);
    localparam logic [22:0] V_MEM_WR  = pk(0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'd6,  0);
    localparam logic [22:0] V_WB_R    = pk(0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 0, 4'b0000, 4'd7,  0);
    localparam logic [22:0] V_WB_I    = pk(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 4'b0000, 4'd8,  0);
    localparam logic [22:0] V_WB_MEM  = pk(0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 4'b0000, 4'd9,  0);
    localparam logic [22:0] V_BR_TK   = pk(1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 4'b0110, 4'd10, 0);
    localparam logic [22:0] V_BR_NT   = pk(0, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 4'b0110, 4'd10, 0);
    localparam logic [22:0] V_JUMP    = pk(1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'd11, 0);
    localparam logic [22:0] V_TRAP    = pk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'd12, 1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [22:0] exp);
        #1;
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp);
        #1;
        tests++;
        assert (bus.state_o === exp) else begin
            fails++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, bus.state_o, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n         = 1'b0;
        bus.opcode    = 6'b000000;
        bus.funct     = 6'b100000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #2;
        chk("reset_held", V_IDLE);
        tick();
        rst_n = 1'b1;
        chk("idle_cycle1", V_IDLE);
        tick(); chk("idle_cycle2", V_IDLE);
        tick(); chk("first_fetch", V_FETCH);

        // R-type ADD: FETCH, DECODE, EXEC_R, WB_R
        tick(); chk("add_decode", V_DECODE);
        tick(); chk("add_exec_r", V_EXR_ADD);
        tick(); chk("add_wb_r", V_WB_R);
        tick(); bus.opcode = 6'b001101; chk("ori_fetch", V_FETCH);

        // ORI: zero-extend, OR
        tick(); chk("ori_decode", V_DECODE);
        tick(); chk("ori_exec_i", V_EXI_ORI);
        tick(); chk("ori_wb_i", V_WB_I);
        tick(); bus.opcode = 6'b100011; chk("lw_fetch", V_FETCH);

        // LW with three wait cycles in MEM_RD
        tick(); chk("lw_decode", V_DECODE);
        tick(); chk("lw_exec_i", V_EXI_ADD);
        tick(); bus.mem_ready = 1'b0; chk("lw_wait1", V_MEM_RD);
        tick(); chk("lw_wait2", V_MEM_RD);
        tick(); chk("lw_wait3", V_MEM_RD);
        tick(); bus.mem_ready = 1'b1; chk("lw_ready", V_MEM_RD);
        tick(); chk("lw_wb_mem", V_WB_MEM);

        // BEQ taken, with one fetch wait cycle
        tick(); bus.opcode = 6'b000100; bus.zero = 1'b1; bus.mem_ready = 1'b0;
        chk("beq_fetch_wait", V_FWAIT);
        tick(); chk("beq_fetch_hold", V_FWAIT);
        bus.mem_ready = 1'b1; chk("beq_fetch_rdy", V_FETCH);
        tick(); chk("beq_decode", V_DECODE);
        tick(); bus.mem_ready = 1'b0; chk("beq_branch", V_BR_TK);
        tick(); bus.mem_ready = 1'b1; bus.opcode = 6'b000101; chk("bne_fetch", V_FETCH);

        // BNE with zero=1: not taken
        tick(); chk("bne_decode", V_DECODE);
        tick(); chk("bne_branch", V_BR_NT);
        tick(); bus.opcode = 6'b000010; chk("j_fetch", V_FETCH);

        tick(); chk("j_decode", V_DECODE);
        tick(); chk("j_jump", V_JUMP);
        tick(); bus.opcode = 6'b111111; chk("ill_fetch", V_FETCH);
        tick(); chk("ill_decode", V_DECODE);
        tick();
`ifdef ILLEGAL_TRAP_EN
        chk("trap_enter", V_TRAP);
        tick(); chk("trap_hold1", V_TRAP);
        tick(); chk("trap_hold2", V_TRAP);
        rst_n = 1'b0;
        chk("trap_reset", V_IDLE);
        tick();
        rst_n = 1'b1;
        chk("rerun_idle1", V_IDLE);
        tick(); chk("rerun_idle2", V_IDLE);
        tick(); chk("rerun_fetch", V_FETCH);
`else
        chk("ill_op_nop", V_FETCH);
        bus.opcode = 6'b000000; bus.funct = 6'b111111;
        tick(); chk("ill_fn_decode", V_DECODE);
        tick(); chk_st("ill_fn_exec_r", 4'd3);
        tick(); chk("ill_fn_nop", V_FETCH);
`endif

        // SW, then reset asserted mid-cycle while waiting in MEM_WR
        bus.opcode = 6'b101011; bus.funct = 6'b100000;
        tick(); chk("sw_decode", V_DECODE);
        tick(); chk("sw_exec_i", V_EXI_ADD);
        tick(); bus.mem_ready = 1'b0; chk("sw_mem_wr", V_MEM_WR);
        #2;
        rst_n = 1'b0;
        chk("sw_async_abort", V_IDLE);
        tick(); chk("sw_abort_hold", V_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_seq.md
Name: mc_ctrl_seq

Overview:
Multi-cycle control sequencer for the MIPS-style datapath (PC, instruction/data memory, register file, ALU). It replaces single-cycle decode. Each instruction is split into FETCH/DECODE/EXEC/MEM/WB steps. Every datapath enable and mux select is driven from one state register, and memory accesses stall on a ready handshake. It sits beside the datapath top and takes opcode/funct from the instruction register and zero from the ALU.

Parameters:
RESET_HOLD, 2, cycles spent in IDLE after reset deassertion before the first FETCH (1..15).
ALU_CTRL_W, 4, width of alu_ctrl.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (low = reset)
opcode  input  6  instruction[31:26] from the IR
funct  input  6  instruction[5:0] from the IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory access complete this cycle
pc_write  output  1  load PC
pc_src  output  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target
ir_write  output  1  load IR
i_or_d  output  1  memory address select: 0 PC, 1 ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_to_reg  output  1  register write data: 1 MDR, 0 ALUOut
reg_dst  output  1  write register: 1 rd, 0 rt
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A: 0 PC, 1 bus_a
alu_src_b  output  2  ALU B: 00 bus_b, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
ext_op  output  1  1 sign-extend, 0 zero-extend
alu_ctrl  output  ALU_CTRL_W  ALU operation code
state_o  output  4  current state, for debug
illegal  output  1  illegal-instruction flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE and hold counter=0. Every output is 0 (state_o=IDLE=0). The counter is the only other flop, except the trap flag.
- Outputs are combinational from state, opcode, funct and zero (Moore, plus the branch qualifier). There are no registered outputs.
- IDLE: all outputs 0. The counter increments each cycle; at RESET_HOLD-1 the next state is FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1. That cycle advances to DECODE.
  - While mem_ready=0 the state holds and the read request stays asserted.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=ADD (branch target goes to ALUOut). Next state by opcode:
  - R-type 000000 -> EXEC_R
  - LW 100011 / SW 101011 / ADDI 001000 / ORI 001101 -> EXEC_I
  - BEQ 000100 / BNE 000101 -> BRANCH
  - J 000010 -> JUMP
  - anything else -> ILLEGAL handling (see Optional Feature)
- EXEC_R: alu_src_a=1, alu_src_b=00. alu_ctrl is decoded from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL, 000010 SRL. An unknown funct is illegal. Next state is WB_R.
- EXEC_I: alu_src_a=1, alu_src_b=10, ext_op=1, alu_ctrl=ADD. For ORI, ext_op=0 and alu_ctrl=OR. Next state: LW -> MEM_RD, SW -> MEM_WR, ADDI/ORI -> WB_I.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to WB_MEM.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready, then goes to FETCH.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=SUB, pc_src=01. pc_write=zero for BEQ, ~zero for BNE. -> FETCH.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001.
- Latency in cycles with zero wait: R/ADDI/ORI 4, LW 5, SW 4, BEQ/BNE 3, J 3. Each memory wait cycle adds 1.
- If rst asserts mid-instruction, the FSM aborts immediately to IDLE. A partial write is never completed, and pc_write/reg_write drop in the same cycle.
- mem_ready in a non-memory state is ignored.
- State encodings (4 bits): IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_MEM 9, BRANCH 10, JUMP 11, TRAP 12. Unreachable codes go to IDLE.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- When defined: an illegal opcode/funct goes from DECODE (or EXEC_R) to TRAP. TRAP drives all outputs 0 except illegal=1 and stays there until reset. The illegal flag is sticky.
- When undefined: an illegal instruction goes to FETCH as a NOP (PC was already incremented), no write occurs, illegal is tied to 0, and the TRAP state does not exist.

Decomposition:
- A shared package holds: the opcode constants, the funct constants, the ALU control codes, the state enum, and the pc_src/alu_src_b encodings. The same ALU codes are reused by the ALU.
- One sub-module, mc_alu_dec: a combinational funct/opcode -> alu_ctrl decoder with a legal flag.

Test Plan:
- Reset: rst low, then release with RESET_HOLD=2 -> all outputs 0 for 2 cycles, FETCH (state_o=1) on cycle 3.
- R-type ADD (funct 100000), mem_ready tied 1 -> states 1,2,3,7. alu_ctrl=0010 in EXEC_R. reg_write=1, reg_dst=1 only in WB_R. 4 cycles total.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_read, i_or_d held high 4 cycles. WB_MEM follows with mem_to_reg=1. 8 cycles total.
- BEQ with zero=1 gives pc_write=1, pc_src=01; BNE with zero=1 gives pc_write=0. Both return to FETCH.
- Illegal opcode 111111 -> with ILLEGAL_TRAP_EN: state 12, illegal=1, persists. Without it: next state FETCH, no reg_write/mem_write.
- rst asserted during MEM_WR -> mem_write drops asynchronously, state_o=0 in the same cycle.
